// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared types and constants for the iterative multiply/divide unit.
// Optional build macro used across the unit: MULDIV_DIVZERO_FLAG_EN.
package mul_div_pkg;

    // Sequencer states: capture, iterate, sign-fix/writeback, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Operation select encoding on the op input.
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Width of an iteration counter that must hold the value n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mul_div_if.sv
// mul_div_if: request/response bundle between pipeline control and the
// multiply/divide unit. div_zero exists only when MULDIV_DIVZERO_FLAG_EN is defined.
interface mul_div_if #(
    parameter int N = 32
);
    logic         start;
    logic         op;
    logic         sgn;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic         div_zero;
`endif

    // Pipeline control side: issues operations, observes status and results.
    modport master (
        output start, op, sgn, a, b,
        input  busy, done, hi, lo
`ifdef MULDIV_DIVZERO_FLAG_EN
        , input div_zero
`endif
    );

    // Unit side: accepts operations, returns status and HI/LO.
    modport slave (
        input  start, op, sgn, a, b,
        output busy, done, hi, lo
`ifdef MULDIV_DIVZERO_FLAG_EN
        , output div_zero
`endif
    );
endinterface

// File: rtl/mul_div_signfix.sv
// mul_div_signfix: combinational conditional two's-complement negation.
// Used to take magnitudes of signed operands at capture and to restore
// result signs before writeback.
module mul_div_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? -value : value;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS-style mult/multu/div/divu feeding HI/LO.
// One result bit per cycle: N CALC cycles, one FIX cycle, one DONE cycle.
// Build option: define MULDIV_DIVZERO_FLAG_EN to add the div_zero status flag.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int N = 32
) (
    input  logic clk,
    input  logic reset,
    mul_div_if.slave bus
);

    localparam int CW = cnt_width(N);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2*N-1:0]    acc;      // mult: {partial product, multiplier}; div: low half is dividend/quotient
    logic [N-1:0]      rem;      // division partial remainder (always below the divisor)
    logic [N-1:0]      opnd;     // mult: multiplicand magnitude; div: divisor magnitude
    logic [N-1:0]      a_raw;    // unmodified dividend, returned on divide by zero
    logic              op_r;
    logic              neg_res;  // product/quotient must be negated
    logic              neg_rem;  // remainder takes the dividend's sign
    logic              div0;
    logic              busy_q;
    logic              done_q;
    logic [N-1:0]      hi_q;
    logic [N-1:0]      lo_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic              div_zero_q;
`endif

    // Operand magnitudes at capture time.
    logic         a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;

    assign a_neg = bus.sgn & bus.a[N-1];
    assign b_neg = bus.sgn & bus.b[N-1];

    mul_div_signfix #(.W(N)) u_a_abs (.value(bus.a), .neg(a_neg), .result(a_mag));
    mul_div_signfix #(.W(N)) u_b_abs (.value(bus.b), .neg(b_neg), .result(b_mag));

    // One shift-add multiply step: add multiplicand when the low bit is set, then shift right.
    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next;

    assign mul_sum  = acc[0] ? ({1'b0, acc[2*N-1:N]} + {1'b0, opnd})
                             : {1'b0, acc[2*N-1:N]};
    assign mul_next = {mul_sum, acc[N-1:1]};

    // One restoring divide step on the (N+1)-bit shifted partial remainder.
    logic [N:0]   partial;
    logic         div_ge;
    logic [N-1:0] rem_sub;

    assign partial = {rem, acc[N-1]};
    assign div_ge  = partial >= {1'b0, opnd};
    // The true difference is below the divisor, so N-bit wraparound arithmetic is exact.
    assign rem_sub = partial[N-1:0] - opnd;

    // Sign restoration applied in FIX.
    logic [2*N-1:0] prod_fixed;
    logic [N-1:0]   quo_fixed;
    logic [N-1:0]   rem_fixed;

    mul_div_signfix #(.W(2*N)) u_prod_fix (.value(acc),        .neg(neg_res), .result(prod_fixed));
    mul_div_signfix #(.W(N))   u_quo_fix  (.value(acc[N-1:0]), .neg(neg_res), .result(quo_fixed));
    mul_div_signfix #(.W(N))   u_rem_fix  (.value(rem),        .neg(neg_rem), .result(rem_fixed));

    // Select the HI/LO values written at the end of FIX.
    logic [N-1:0] res_hi;
    logic [N-1:0] res_lo;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        res_hi = prod_fixed[2*N-1:N];
        res_lo = prod_fixed[N-1:0];
        if (op_r == OP_DIV) begin
            if (div0) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = rem_fixed;
                res_lo = quo_fixed;
            end
        end
    end

    // Sequencer and datapath registers; outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            rem        <= '0;
            opnd       <= '0;
            a_raw      <= '0;
            op_r       <= OP_MUL;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            div0       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_r    <= bus.op;
                        a_raw   <= bus.a;
                        div0    <= (bus.b == '0);
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        cnt     <= CW'(N);
                        rem     <= '0;
                        if (bus.op == OP_MUL) begin
                            acc  <= {{N{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end else begin
                            acc  <= {{N{1'b0}}, a_mag};
                            opnd <= b_mag;
                        end
                        busy_q  <= 1'b1;
                        state   <= CALC;
                    end else begin
                        state   <= IDLE;
                    end
                end
                CALC: begin
                    if (op_r == OP_MUL) begin
                        acc <= mul_next;
                    end else begin
                        acc[N-1:0] <= {acc[N-2:0], div_ge};
                        rem        <= div_ge ? rem_sub : partial[N-1:0];
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi_q       <= res_hi;
                    lo_q       <= res_lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
                    div_zero_q <= (op_r == OP_DIV) && div0;
`endif
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state      <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
    assign bus.div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit (N=32).
// Cycle 0 is the cycle start is presented; cycle k is the k-th cycle after
// the sampling edge. Outputs are sampled on the falling edge.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    localparam int N   = 32;
    localparam int LAT = N + 2;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    mul_div_if #(.N(N)) bus ();

    mul_div_unit #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operation for one sampling edge; operands are scrambled afterwards
    // unless start is held for back-to-back issue.
    task automatic launch(input logic o, input logic s, input logic [N-1:0] x,
                          input logic [N-1:0] y, input bit hold);
        @(negedge clk);
        bus.op    = o;
        bus.sgn   = s;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(posedge clk);
        if (!hold) begin
            #1;
            bus.start = 1'b0;
            bus.op    = ~o;
            bus.sgn   = ~s;
            bus.a     = 32'hDEAD_BEEF;
            bus.b     = 32'h0000_0000;
        end
    endtask

    // Wait (bounded) for the done pulse; must be called right after the sampling edge.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input int cyc,
                                input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo);
        total++;
        if (cyc !== LAT) $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, LAT);
        else passed++;
        total++;
        if (bus.hi !== exp_hi) $display("FAIL %s hi: got %h, want %h", name, bus.hi, exp_hi);
        else passed++;
        total++;
        if (bus.lo !== exp_lo) $display("FAIL %s lo: got %h, want %h", name, bus.lo, exp_lo);
        else passed++;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== '0)
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all zero",
                     bus.busy, bus.done, bus.hi, bus.lo);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_multu();
        int  cyc;
        bit  busy_ok;
        bit  hold_ok;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        cyc     = 0;
        launch(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.busy !== ((i >= 1) && (i <= LAT - 1))) busy_ok = 1'b0;
            if (i < LAT && (bus.hi !== '0 || bus.lo !== '0)) hold_ok = 1'b0;
            if (bus.done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        total++;
        if (!busy_ok) $display("FAIL multu busy_window: busy not high exactly in cycles 1..%0d", LAT - 1);
        else passed++;
        total++;
        if (!hold_ok) $display("FAIL multu hilo_hold: hi/lo changed before done, now hi=%h lo=%h", bus.hi, bus.lo);
        else passed++;
        check_result("multu_max", cyc, 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0) $display("FAIL multu done_pulse: done=%b one cycle later, want 0", bus.done);
        else passed++;
    endtask

    task automatic test_mult_signed();
        int cyc;
        launch(OP_MUL, 1'b1, -32'sd3, 32'sd5, 1'b0);
        wait_done(cyc);
        check_result("mult_neg3x5", cyc, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    endtask

    task automatic test_divide();
        int cyc;
        launch(OP_DIV, 1'b1, -32'sd7, 32'sd2, 1'b0);
        wait_done(cyc);
        check_result("div_neg7_2", cyc, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        launch(OP_DIV, 1'b0, 32'd100, 32'd7, 1'b0);
        wait_done(cyc);
        check_result("divu_100_7", cyc, 32'd2, 32'd14);
    endtask

    task automatic test_div_corners();
        int cyc;
        launch(OP_DIV, 1'b0, 32'h0000_1234, 32'h0, 1'b0);
        wait_done(cyc);
        check_result("divu_by_zero", cyc, 32'h0000_1234, 32'hFFFF_FFFF);
`ifdef MULDIV_DIVZERO_FLAG_EN
        total++;
        if (bus.div_zero !== 1'b1) $display("FAIL div_zero_set: got %b, want 1", bus.div_zero);
        else passed++;
`endif
        launch(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(cyc);
        check_result("div_minneg_m1", cyc, 32'h0, 32'h8000_0000);
`ifdef MULDIV_DIVZERO_FLAG_EN
        total++;
        if (bus.div_zero !== 1'b0) $display("FAIL div_zero_clear: got %b, want 0", bus.div_zero);
        else passed++;
`endif
    endtask

    task automatic test_busy_ignore();
        int cyc;
        bit extra;
        launch(OP_DIV, 1'b0, 32'd100, 32'd7, 1'b0);
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                cyc = i;
                break;
            end
            if (i == 5) begin
                bus.start = 1'b1;
                bus.op    = OP_MUL;
                bus.sgn   = 1'b0;
                bus.a     = 32'd3;
                bus.b     = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
        end
        check_result("busy_ignore", cyc, 32'd2, 32'd14);
        extra = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra = 1'b1;
        end
        total++;
        if (extra) $display("FAIL busy_ignore extra_op: got a second operation, want none");
        else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        launch(OP_MUL, 1'b1, -32'sd3, 32'sd5, 1'b1);
        wait_done(cyc);
        check_result("b2b_first", cyc, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        bus.op  = OP_DIV;
        bus.sgn = 1'b1;
        bus.a   = -32'sd7;
        bus.b   = 32'sd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'h0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL b2b no_idle: busy=%b done=%b after DONE, want busy=1 done=0", bus.busy, bus.done);
        else passed++;
        cyc = 0;
        for (int i = 2; i <= 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        check_result("b2b_second", cyc, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    endtask

    task automatic test_reset_midop();
        int cyc;
        bit seen;
        launch(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        for (int i = 1; i <= 10; i++) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== '0)
            $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h, want all zero",
                     bus.busy, bus.done, bus.hi, bus.lo);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < LAT + 6; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) $display("FAIL reset_midop no_done: got a done pulse after reset, want none");
        else passed++;
        launch(OP_MUL, 1'b0, 32'd6, 32'd7, 1'b0);
        wait_done(cyc);
        check_result("multu_6x7", cyc, 32'd0, 32'd42);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.sgn   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_multu();
        test_mult_signed();
        test_divide();
        test_div_corners();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
